sync_fifo_flex: RTL and testbench

- Parametrised next-generation synchronous FIFO for event/pixel data buffering between producer and consumer logic in one clock domain.
- Adds over the basic FIFO:
  - selectable show-ahead (FWFT) or registered-read mode
  - programmable almost-full/almost-empty thresholds
  - synchronous flush
  - sticky overflow/underflow error flags
  - high-water-mark occupancy tracking for buffer sizing.

---
 rtl/sync_fifo_flex_if.sv | 36 +++
 rtl/sync_fifo_flex.sv | 103 ++++++++++
 tb/tb_sync_fifo_flex.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_flex_if.sv
// Handshake/status bundle between a producer/consumer and sync_fifo_flex.
// The master side drives requests; the slave side (the FIFO) returns data and status.
interface sync_fifo_flex_if #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              flush;
    logic              wr_en;
    logic [DWIDTH-1:0] wdata;
    logic              rd_en;
    logic              clr_err;
    logic [DWIDTH-1:0] rdata;
    logic              rvalid;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [CW-1:0]     numel;
    logic [CW-1:0]     high_water;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, wr_en, wdata, rd_en, clr_err,
        input  rdata, rvalid, empty, full, almost_empty, almost_full,
               numel, high_water, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, wdata, rd_en, clr_err,
        output rdata, rvalid, empty, full, almost_empty, almost_full,
               numel, high_water, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with show-ahead or registered read, programmable thresholds,
// flush, sticky error flags and high-water-mark tracking.
module sync_fifo_flex #(
    parameter int DWIDTH    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    sync_fifo_flex_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_nxt, hw_q;
    logic              ovf_q, unf_q;
    logic              empty_c, full_c, wr_acc, rd_acc;

    assign empty_c = (count == '0);
    assign full_c  = (count == DEPTH_C);

    // Flush blocks both accepts so a flush edge never moves data or raises errors.
    assign wr_acc = bus.wr_en & ~full_c  & ~bus.flush;
    assign rd_acc = bus.rd_en & ~empty_c & ~bus.flush;

    assign count_nxt = bus.flush ? '0 : (count + CW'(wr_acc) - CW'(rd_acc));

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hw_q   <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hw_q   <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            if (count_nxt > hw_q) hw_q <= count_nxt;
        end
    end

    // Set beats clear; flush neither sets nor implicitly clears the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.wr_en & full_c & ~bus.flush) ovf_q <= 1'b1;
            else if (bus.clr_err)                ovf_q <= 1'b0;
            if (bus.rd_en & empty_c & ~bus.flush) unf_q <= 1'b1;
            else if (bus.clr_err)                 unf_q <= 1'b0;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.rdata  = mem[rd_ptr];
            assign bus.rvalid = ~empty_c;
        end else begin : g_reg
            logic [DWIDTH-1:0] rdata_q;
            logic              rvalid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem[rd_ptr];
                end
            end

            assign bus.rdata  = rdata_q;
            assign bus.rvalid = rvalid_q;
        end
    endgenerate

    assign bus.empty        = empty_c;
    assign bus.full         = full_c;
    assign bus.almost_empty = (count <= AE_C);
    assign bus.almost_full  = (count >= AF_C);
    assign bus.numel        = count;
    assign bus.high_water   = hw_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_flex.sv
// Drives a show-ahead and a registered-read FIFO with identical traffic and
// compares both against a queue-based reference model.
module tb_sync_fifo_flex;
    localparam int DW = 8;
    localparam int DP = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 0, wr_en = 0, rd_en = 0, clr_err = 0;
    logic [DW-1:0] wdata = '0;

    always #5 clk = ~clk;

    sync_fifo_flex_if #(.DWIDTH(DW), .DEPTH(DP)) f_if ();
    sync_fifo_flex_if #(.DWIDTH(DW), .DEPTH(DP)) r_if ();

    assign f_if.flush = flush;   assign r_if.flush = flush;
    assign f_if.wr_en = wr_en;   assign r_if.wr_en = wr_en;
    assign f_if.wdata = wdata;   assign r_if.wdata = wdata;
    assign f_if.rd_en = rd_en;   assign r_if.rd_en = rd_en;
    assign f_if.clr_err = clr_err; assign r_if.clr_err = clr_err;

    sync_fifo_flex #(.DWIDTH(DW), .DEPTH(DP), .FWFT(1)) u_fwft (.clk(clk), .rst_n(rst_n), .bus(f_if));
    sync_fifo_flex #(.DWIDTH(DW), .DEPTH(DP), .FWFT(0)) u_reg  (.clk(clk), .rst_n(rst_n), .bus(r_if));

    // Reference model
    logic [DW-1:0] q[$];
    int            m_hw;
    bit            m_ovf, m_unf, m_rv;
    logic [DW-1:0] m_rd;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_hw = 0; m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("numel",     32'(f_if.numel), 32'(n));
        chk("empty",     32'(f_if.empty), 32'(n == 0));
        chk("full",      32'(f_if.full), 32'(n == DP));
        chk("a_empty",   32'(f_if.almost_empty), 32'(n <= 1));
        chk("a_full",    32'(f_if.almost_full), 32'(n >= DP - 2));
        chk("high_water",32'(f_if.high_water), 32'(m_hw));
        chk("overflow",  32'(f_if.overflow), 32'(m_ovf));
        chk("underflow", 32'(f_if.underflow), 32'(m_unf));
        chk("fwft_rvalid", 32'(f_if.rvalid), 32'(n != 0));
        if (n != 0) chk("fwft_rdata", 32'(f_if.rdata), 32'(q[0]));
        chk("reg_numel",  32'(r_if.numel), 32'(n));
        chk("reg_rvalid", 32'(r_if.rvalid), 32'(m_rv));
        chk("reg_rdata",  32'(r_if.rdata), 32'(m_rd));
        chk("reg_ovf",    32'(r_if.overflow), 32'(m_ovf));
    endtask

    // One clock: drive inputs, advance the model by the accept rules, check after the edge.
    task automatic step(input bit wr, input logic [DW-1:0] wd, input bit rd,
                        input bit fl = 1'b0, input bit ce = 1'b0);
        bit is_full, is_empty;
        wr_en = wr; wdata = wd; rd_en = rd; flush = fl; clr_err = ce;
        is_full  = (q.size() == DP);
        is_empty = (q.size() == 0);
        if (fl) begin
            q.delete();
            m_hw = 0;
            m_rv = 0;
            if (ce) begin m_ovf = 0; m_unf = 0; end
        end else begin
            if (wr && is_full) m_ovf = 1; else if (ce) m_ovf = 0;
            if (rd && is_empty) m_unf = 1; else if (ce) m_unf = 0;
            m_rv = rd && !is_empty;
            if (m_rv) m_rd = q.pop_front();
            if (wr && !is_full) q.push_back(wd);
            if (q.size() > m_hw) m_hw = q.size();
        end
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
        check_all();
    endtask

    initial begin
        int pw, pr;
        logic [DW-1:0] d;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Fill 0x01..0x08, then three overflowing writes
        for (int i = 1; i <= 8; i++) step(1, DW'(i), 0);
        for (int i = 0; i < 3; i++) step(1, 8'hAA, 0);
        step(1, 8'hAA, 0, 0, 1);   // set wins over clear
        step(0, 8'h00, 0, 0, 1);   // clear alone
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1);

        // Underflow, then read+write together at empty
        step(0, 8'h00, 1);
        step(1, 8'h55, 1);
        step(0, 8'h00, 0, 0, 1);

        // Wrap-around at steady occupancy of 4
        step(0, 8'h00, 0, 1);
        d = 8'h20;
        for (int i = 0; i < 4; i++) begin step(1, d, 0); d++; end
        for (int i = 0; i < 20; i++) begin step(1, d, 1); d++; end
        step(0, 8'h00, 0, 1);

        // Registered-read latency sequence
        step(1, 8'h10, 0);
        step(1, 8'h11, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        // Flush with numel=5 and overflow set, write on the same edge is dropped
        for (int i = 0; i < 8; i++) step(1, DW'(8'h30 + i), 0);
        step(1, 8'hEE, 0);
        for (int i = 0; i < 3; i++) step(0, 8'h00, 1);
        step(1, 8'h99, 0, 1);
        step(0, 8'h00, 0);

        // Randomized traffic with shifting bias to visit full and empty
        for (int ph = 0; ph < 3; ph++) begin
            pw = (ph == 0) ? 70 : (ph == 1) ? 30 : 50;
            pr = 100 - pw;
            for (int i = 0; i < 200; i++) begin
                step($urandom_range(0, 99) < pw, DW'($urandom),
                     $urandom_range(0, 99) < pr,
                     $urandom_range(0, 29) == 0,
                     $urandom_range(0, 19) == 0);
            end
        end

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) step(1, DW'(8'h60 + i), i[0]);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h77, 0);
        step(0, 8'h00, 1);
        step(0, 8'h00, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
